wheel_direction_detector: RTL
=============================

WHEEL_DIRECTION_DETECTOR -- requirements
Module: wheel_direction_detector

Interface
REQ-001 SHALL have parameter DEBOUNCE, default 8, the number of consecutive stable cycles (2..255) needed to accept a sensor level change.
REQ-002 SHALL have parameter TIMEOUT, default 16'd50000, the maximum number of cycles allowed in any non-IDLE state.
REQ-003 SHALL have port Clk, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: asynchronous, active-low reset (low = reset).
REQ-005 SHALL have port sensor_a, input, 1 bit: raw wheel sensor A, asynchronous to Clk; 1 = wheel present.
REQ-006 SHALL have port sensor_b, input, 1 bit: raw wheel sensor B, downstream of A; 1 = wheel present.
REQ-007 SHALL have port a2b, output reg, 1 bit: single-cycle pulse, one wheel completed A-to-B.
REQ-008 SHALL have port b2a, output reg, 1 bit: single-cycle pulse, one wheel completed B-to-A.
REQ-009 SHALL have port fault, output reg, 1 bit: single-cycle pulse on an illegal sequence or timeout.

Function
REQ-010 SHALL pass each sensor through a 2-flop synchronizer before any other use.
REQ-011 SHALL debounce each synchronized sensor independently with an 8-bit counter, as follows:
- Counter clears whenever the synchronized value equals the debounced value.
- Debounced value takes the new level on the DEBOUNCE-th consecutive edge of difference.
- Total latency from a raw change to the debounced change is DEBOUNCE+2 cycles.
REQ-012 SHALL run a one-hot or encoded FSM on the debounced pair (a,b) with states IDLE, A1, AB_A, B_A, B1, AB_B, A_B, FLT.
REQ-013 SHALL apply these transitions from IDLE: (1,0)->A1, (0,1)->B1, (1,1)->FLT with fault pulse.
REQ-014 SHALL track the A-to-B direction as follows:
- A1: (1,1)->AB_A; (0,0)->IDLE with no pulse (wheel retreated).
- AB_A: (0,1)->B_A; (1,0)->A1 (reversal).
- B_A: (0,0)->IDLE with a2b=1 on that same edge; (1,1)->AB_A.
REQ-015 SHALL track the B-to-A direction symmetrically through B1, AB_B and A_B, pulsing b2a on the A_B->IDLE edge.
REQ-016 SHALL treat any (a,b) combination not listed for the current state (e.g. (0,0) in AB_A, a direct (1,0)<->(0,1) jump) as illegal: go to FLT and pulse fault for one cycle.
REQ-017 SHALL keep a 16-bit timeout counter that clears on IDLE, increments in every other state and saturates; when it reaches TIMEOUT it SHALL enter FLT and pulse fault once.
REQ-018 SHALL remain in FLT, emitting no pulses, until the debounced pair is (0,0) for one cycle, then return to IDLE.
REQ-019 SHALL never assert a2b, b2a and fault in the same cycle; each pulse SHALL be exactly one cycle wide.
REQ-020 SHALL keep the pulse outputs compatible with a downstream bogey counter sampling on the same Clk, with no gap required between consecutive wheel pulses.

Reset
REQ-021 SHALL, while Reset=0, force asynchronously: a2b=0, b2a=0, fault=0, FSM=IDLE, synchronizers=0, debounced values=0, and all counters=0.
REQ-022 SHALL, on Reset release mid-wheel with sensors already active, follow the normal rules: (1,0) enters A1, (1,1) enters FLT.

Verification (DEBOUNCE=4, TIMEOUT=100)
REQ-023 SHALL verify a clean A-to-B wheel: raw (1,0),(1,1),(0,1),(0,0), each held 10 cycles -> exactly one a2b pulse, 6 cycles after the raw (0,0); no b2a or fault.
REQ-024 SHALL verify glitch rejection: a 3-cycle pulse on sensor_a from IDLE -> FSM stays IDLE, no outputs; a 4-cycle stable pulse -> A1 entered, then IDLE with no pulse.
REQ-025 SHALL verify reversal: (1,0),(1,1),(1,0),(0,0) -> no a2b, no b2a, no fault; a following B-to-A wheel -> one b2a.
REQ-026 SHALL verify the illegal jump and timeout cases:
- (1,0) then directly (0,1) -> one fault pulse, FSM=FLT; after (0,0), FSM=IDLE.
- sensor_a held at 1 for 200 cycles -> one fault at the 100th cycle in A1.
REQ-027 SHALL verify reset and burst behaviour:
- Reset asserted mid-AB_A -> all outputs 0 immediately.
- After release with raw (0,0) -> IDLE; 4 back-to-back A-to-B wheels -> exactly 4 a2b pulses.

Source files
------------

// File: rtl/wheel_direction_detector.sv
// Wheel direction detector for a two-sensor track section.
//
// Each raw sensor is synchronised (2 flops) and debounced (8-bit run counter).
// The debounced pair (a,b) is then walked through a small FSM that recognises
// a complete wheel passing A->B or B->A. Any out-of-order pattern, or
// lingering too long in a tracking state, is reported as a fault.
//
// Ports:
//   Clk      - system clock, rising-edge active
//   Reset    - asynchronous active-low reset
//   sensor_a - raw sensor A (asynchronous), 1 = wheel present
//   sensor_b - raw sensor B (asynchronous, downstream of A), 1 = wheel present
//   a2b      - one-cycle pulse: one wheel completed A-to-B
//   b2a      - one-cycle pulse: one wheel completed B-to-A
//   fault    - one-cycle pulse: illegal sequence or timeout
module wheel_direction_detector #(
  parameter int unsigned DEBOUNCE = 8,
  parameter logic [15:0] TIMEOUT  = 16'd50000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic sensor_a,
  input  logic sensor_b,
  output logic a2b,
  output logic b2a,
  output logic fault
);

  localparam logic [7:0]  DebLast = 8'(DEBOUNCE - 1);
  localparam logic [15:0] TmoLast = TIMEOUT - 16'd1;

  // Bit 1 carries sensor A, bit 0 carries sensor B throughout.
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      deb_q, deb_d;
  logic [1:0][7:0] cnt_q, cnt_d;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= {sensor_a, sensor_b};
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter tracks how many consecutive edges the synchronised level has
  // disagreed with the debounced level; the DEBOUNCE-th disagreement commits.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DebLast) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  // StBA: only B covered while travelling A->B.
  // StAB: only A covered while travelling B->A.
  typedef enum logic [2:0] {
    StIdle,
    StA1,
    StAbA,
    StBA,
    StB1,
    StAbB,
    StAB,
    StFlt
  } state_e;

  state_e      state_q;
  logic [15:0] tmo_q;
  logic [1:0]  ab;
  logic        tmo_hit;

  // The FSM acts on the level being committed this edge, so a wheel pulse
  // lands on the same edge the debounced pair changes.
  assign ab      = deb_d;
  assign tmo_hit = (state_q != StIdle) && (state_q != StFlt) && (tmo_q >= TmoLast);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      tmo_q   <= '0;
      a2b     <= 1'b0;
      b2a     <= 1'b0;
      fault   <= 1'b0;
    end else begin
      a2b   <= 1'b0;
      b2a   <= 1'b0;
      fault <= 1'b0;

      if (state_q == StIdle) begin
        tmo_q <= '0;
      end else if (tmo_q != 16'hFFFF) begin
        tmo_q <= tmo_q + 16'd1;
      end

      if (tmo_hit) begin
        state_q <= StFlt;
        fault   <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            case (ab)
              2'b10:   state_q <= StA1;
              2'b01:   state_q <= StB1;
              2'b11:   begin state_q <= StFlt; fault <= 1'b1; end
              default: state_q <= StIdle;
            endcase
          end
          StA1: begin
            case (ab)
              2'b10:   state_q <= StA1;
              2'b11:   state_q <= StAbA;
              2'b00:   state_q <= StIdle;  // wheel backed off, nothing to report
              default: begin state_q <= StFlt; fault <= 1'b1; end
            endcase
          end
          StAbA: begin
            case (ab)
              2'b11:   state_q <= StAbA;
              2'b01:   state_q <= StBA;
              2'b10:   state_q <= StA1;
              default: begin state_q <= StFlt; fault <= 1'b1; end
            endcase
          end
          StBA: begin
            case (ab)
              2'b01:   state_q <= StBA;
              2'b00:   begin state_q <= StIdle; a2b <= 1'b1; end
              2'b11:   state_q <= StAbA;
              default: begin state_q <= StFlt; fault <= 1'b1; end
            endcase
          end
          StB1: begin
            case (ab)
              2'b01:   state_q <= StB1;
              2'b11:   state_q <= StAbB;
              2'b00:   state_q <= StIdle;
              default: begin state_q <= StFlt; fault <= 1'b1; end
            endcase
          end
          StAbB: begin
            case (ab)
              2'b11:   state_q <= StAbB;
              2'b10:   state_q <= StAB;
              2'b01:   state_q <= StB1;
              default: begin state_q <= StFlt; fault <= 1'b1; end
            endcase
          end
          StAB: begin
            case (ab)
              2'b10:   state_q <= StAB;
              2'b00:   begin state_q <= StIdle; b2a <= 1'b1; end
              2'b11:   state_q <= StAbB;
              default: begin state_q <= StFlt; fault <= 1'b1; end
            endcase
          end
          StFlt: begin
            // Silent until the track is seen empty.
            if (ab == 2'b00) begin
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
